cle_label_stat: RTL
===================

Name: cle_label_stat

Overview:
- Downstream stage of the connected-component labeling engine.
- After labeling finishes, scans the 32x32 label image in SRAM, one 8-bit label per address. Address = {row[4:0], col[4:0]}; label 0 = background.
- Accumulates per-label area and bounding box, then streams one record per present label to the result consumer over a valid/ready handshake.

Parameters:
- MAX_LABEL, 15, highest label id tracked (table entries 1..MAX_LABEL); legal range 1..255.
- IMG_W_LOG2, 5, log2 of image width/height; address width = 2*IMG_W_LOG2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse, tied to the labeler's finish; ignored unless in IDLE.
- sram_a  output  10  label SRAM read address.
- sram_q  input  8  label SRAM read data; valid one cycle after sram_a.
- out_valid  output  1  record valid.
- out_ready  input  1  consumer accepts record.
- out_label  output  8  label id of record.
- out_area  output  11  pixel count, 1..1024.
- out_xmin, out_xmax, out_ymin, out_ymax  output  5 each  bounding box (col = x, row = y).
- ovf  output  1  sticky per run: a pixel with label > MAX_LABEL was seen.
- busy  output  1  high from cycle after accepted start until done.
- done  output  1  one-cycle pulse after the last record is accepted (or after the scan, if no labels).

Behaviour:
- Reset (async, reset==0): state IDLE; sram_a=0; all outputs 0; table cleared.
- Table entry per label: area[10:0], xmin, xmax, ymin, ymax.
  - Cleared state: area=0, min fields=31, max fields=0.
- State machine: IDLE -> SCAN -> FLUSH -> EMIT -> FIN -> IDLE.
- IDLE:
  - On start: clear whole table and ovf in the same edge; go to SCAN with sram_a=0; busy=1 next cycle.
- SCAN:
  - sram_a increments by 1 every cycle, 0..1023.
  - A 1-cycle delayed copy of the address tags returning sram_q.
  - Each returned pixel with label L:
    - 1<=L<=MAX_LABEL: area+=1; min/max fields updated with the tagged x/y.
    - L==0: no effect.
    - L>MAX_LABEL: ovf=1; no table effect.
  - After issuing address 1023, go to FLUSH; sram_a holds 1023.
- FLUSH: one cycle to process the pixel at address 1023; then EMIT with scan index = 1.
- EMIT:
  - Scan index walks 1..MAX_LABEL ascending; entries with area==0 are skipped, one index per cycle.
  - Entry with area>0: present on out_* with out_valid=1.
  - out_* stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: advance; next record earliest the following cycle, so back-to-back records are allowed.
  - After index MAX_LABEL is handled, go to FIN.
- FIN: done=1 for one cycle, busy=0, out_valid=0, back to IDLE.
- Scan latency: 1025 cycles from the cycle after start to entering EMIT.
- Width rules:
  - Area never exceeds 1024, so 11 bits; no saturation needed.
  - Compares are unsigned 5-bit.
- Boundary conditions:
  - Label 0 across the whole image: EMIT emits nothing; done follows.
  - Single-pixel label: xmin=xmax, ymin=ymax, area=1.
  - Pixel at (0,0) or (31,31) must set the min/max extremes correctly.
  - Table retains results after done until the next start.
  - start during SCAN/FLUSH/EMIT/FIN is ignored; no restart.
  - out_ready high while out_valid low has no effect.
  - Reset mid-run aborts immediately: out_valid, busy, done = 0; next start begins a fresh scan.

Test Plan:
- All-zero image, start pulse -> no out_valid; done pulse exactly 1026 cycles after the start cycle (1025 scan cycles + FIN); ovf=0.
- Label 3 filling rows 2..4, cols 5..9; label 1 single pixel at (31,31); out_ready=1 -> records in order: {label 1, area 1, x 31..31, y 31..31}, then {label 3, area 15, x 5..9, y 2..4}; then done.
- All 1024 pixels = label 15 -> one record: area=1024, box 0..31 x 0..31.
- Image containing label 200 at (10,10) plus label 2 at (0,0) -> ovf=1; only the label-2 record, area 1, box 0..0.
- Backpressure: two labels present, out_ready held low 5 cycles then toggled -> first record fields stable while stalled; each record transferred exactly once; done after the second.
- Reset asserted mid-SCAN (address 500) -> outputs cleared asynchronously; new start gives results matching an uninterrupted run.

Source files
------------

// File: rtl/cle_label_stat_if.sv
// rtl/cle_label_stat_if.sv - per-label record stream from the label statistics stage to its consumer
interface cle_label_stat_if #(
   parameter int IMG_W_LOG2 = 5
);
   localparam int CW = IMG_W_LOG2;
   localparam int NW = 2 * IMG_W_LOG2 + 1;

   logic          out_valid;
   logic          out_ready;
   logic [7:0]    out_label;
   logic [NW-1:0] out_area;
   logic [CW-1:0] out_xmin;
   logic [CW-1:0] out_xmax;
   logic [CW-1:0] out_ymin;
   logic [CW-1:0] out_ymax;

   modport master (
      output out_valid, out_label, out_area, out_xmin, out_xmax, out_ymin, out_ymax,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_label, out_area, out_xmin, out_xmax, out_ymin, out_ymax,
      output out_ready
   );
endinterface

// File: rtl/cle_label_stat.sv
// rtl/cle_label_stat.sv - scans the label image, accumulates per-label area and bounding box, streams one record per present label
module cle_label_stat #(
   parameter int MAX_LABEL  = 15,
   parameter int IMG_W_LOG2 = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   output logic [2*IMG_W_LOG2-1:0]   sram_a,
   input  logic [7:0]                sram_q,
   cle_label_stat_if.master          rec,
   output logic                      ovf,
   output logic                      busy,
   output logic                      done
);
   localparam int CW = IMG_W_LOG2;
   localparam int AW = 2 * IMG_W_LOG2;
   localparam int NW = 2 * IMG_W_LOG2 + 1;
   localparam logic [AW-1:0] ADDR_LAST = '1;
   localparam logic [7:0]    MAX_L     = 8'(MAX_LABEL);
   localparam logic [NW-1:0] AREA_ONE  = NW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN,
      S_FLUSH,
      S_EMIT,
      S_FIN
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] tag_q, tag_d;
   logic          pix_vld_q, pix_vld_d;
   logic          ovf_q, ovf_d;
   logic          any_q, any_d;
   logic [7:0]    idx_q, idx_d;

   logic [NW-1:0] area_q [1:MAX_LABEL];
   logic [NW-1:0] area_d [1:MAX_LABEL];
   logic [CW-1:0] xmin_q [1:MAX_LABEL];
   logic [CW-1:0] xmin_d [1:MAX_LABEL];
   logic [CW-1:0] xmax_q [1:MAX_LABEL];
   logic [CW-1:0] xmax_d [1:MAX_LABEL];
   logic [CW-1:0] ymin_q [1:MAX_LABEL];
   logic [CW-1:0] ymin_d [1:MAX_LABEL];
   logic [CW-1:0] ymax_q [1:MAX_LABEL];
   logic [CW-1:0] ymax_d [1:MAX_LABEL];

   logic          pix_hit;
   logic          pix_big;
   logic [CW-1:0] pix_x;
   logic [CW-1:0] pix_y;

   logic [NW-1:0] cur_area;
   logic [CW-1:0] cur_xmin, cur_xmax, cur_ymin, cur_ymax;
   logic          out_valid;
   logic          clear_tbl;

   // Classify the pixel returning from SRAM using the address issued one cycle earlier.
   always_comb begin
      pix_x   = tag_q[CW-1:0];
      pix_y   = tag_q[AW-1:CW];
      pix_hit = pix_vld_q && (sram_q != 8'd0) && (sram_q <= MAX_L);
      pix_big = pix_vld_q && (sram_q > MAX_L);
   end

   // Select the table entry under the emit index for presentation on the record stream.
   always_comb begin
      cur_area = '0;
      cur_xmin = '0;
      cur_xmax = '0;
      cur_ymin = '0;
      cur_ymax = '0;
      for (int i = 1; i <= MAX_LABEL; i++) begin
         if (idx_q == 8'(i)) begin
            cur_area = area_q[i];
            cur_xmin = xmin_q[i];
            cur_xmax = xmax_q[i];
            cur_ymin = ymin_q[i];
            cur_ymax = ymax_q[i];
         end
      end
   end

   // Next-state and outputs of the scan/emit controller.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      tag_d     = addr_q;
      pix_vld_d = 1'b0;
      ovf_d     = ovf_q | pix_big;
      any_d     = any_q | pix_hit;
      idx_d     = idx_q;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      clear_tbl = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clear_tbl = 1'b1;
               ovf_d     = 1'b0;
               any_d     = 1'b0;
               addr_d    = '0;
               state_d   = S_SCAN;
            end
         end
         S_SCAN: begin
            busy      = 1'b1;
            pix_vld_d = 1'b1;
            if (addr_q == ADDR_LAST) begin
               state_d = S_FLUSH;
            end else begin
               addr_d = addr_q + AW'(1);
            end
         end
         S_FLUSH: begin
            // With no labelled pixel in the whole image the index walk is
            // pointless, so go straight to FIN.
            busy    = 1'b1;
            idx_d   = 8'd1;
            state_d = (any_q || pix_hit) ? S_EMIT : S_FIN;
         end
         S_EMIT: begin
            busy      = 1'b1;
            out_valid = (cur_area != '0);
            if (!out_valid || rec.out_ready) begin
               if (idx_q == MAX_L) begin
                  state_d = S_FIN;
               end else begin
                  idx_d = idx_q + 8'd1;
               end
            end
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Table update: full clear on an accepted start, otherwise fold in the returning pixel.
   always_comb begin
      for (int i = 1; i <= MAX_LABEL; i++) begin
         area_d[i] = area_q[i];
         xmin_d[i] = xmin_q[i];
         xmax_d[i] = xmax_q[i];
         ymin_d[i] = ymin_q[i];
         ymax_d[i] = ymax_q[i];
         if (clear_tbl) begin
            area_d[i] = '0;
            xmin_d[i] = '1;
            xmax_d[i] = '0;
            ymin_d[i] = '1;
            ymax_d[i] = '0;
         end else if (pix_hit && (sram_q == 8'(i))) begin
            area_d[i] = area_q[i] + AREA_ONE;
            if (pix_x < xmin_q[i]) xmin_d[i] = pix_x;
            if (pix_x > xmax_q[i]) xmax_d[i] = pix_x;
            if (pix_y < ymin_q[i]) ymin_d[i] = pix_y;
            if (pix_y > ymax_q[i]) ymax_d[i] = pix_y;
         end
      end
   end

   // Controller registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         tag_q     <= '0;
         pix_vld_q <= 1'b0;
         ovf_q     <= 1'b0;
         any_q     <= 1'b0;
         idx_q     <= 8'd0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         tag_q     <= tag_d;
         pix_vld_q <= pix_vld_d;
         ovf_q     <= ovf_d;
         any_q     <= any_d;
         idx_q     <= idx_d;
      end
   end

   // Per-label statistics table.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 1; i <= MAX_LABEL; i++) begin
            area_q[i] <= '0;
            xmin_q[i] <= '1;
            xmax_q[i] <= '0;
            ymin_q[i] <= '1;
            ymax_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i <= MAX_LABEL; i++) begin
            area_q[i] <= area_d[i];
            xmin_q[i] <= xmin_d[i];
            xmax_q[i] <= xmax_d[i];
            ymin_q[i] <= ymin_d[i];
            ymax_q[i] <= ymax_d[i];
         end
      end
   end

   // Record fields read as zero whenever no record is offered.
   always_comb begin
      sram_a        = addr_q;
      ovf           = ovf_q;
      rec.out_valid = out_valid;
      rec.out_label = out_valid ? idx_q    : 8'd0;
      rec.out_area  = out_valid ? cur_area : '0;
      rec.out_xmin  = out_valid ? cur_xmin : '0;
      rec.out_xmax  = out_valid ? cur_xmax : '0;
      rec.out_ymin  = out_valid ? cur_ymin : '0;
      rec.out_ymax  = out_valid ? cur_ymax : '0;
   end
endmodule
